// File: rtl/pck_control.sv
// Shared definitions for the register-file write-back arbiter: requester
// indices, port sizes and the round-robin successor helper.
package pck_control;

   localparam int WB_NB_REQ = 4;
   localparam int WB_ADDR_W = 5;
   localparam int WB_DATA_W = 32;

   // Requester slots on the write-back port; slot 0 is the in-order pipeline,
   // the rest are long-latency units sharing a rotating priority.
   typedef enum logic [1:0] {
      wb_req_pipe   = 2'd0,
      wb_req_muldiv = 2'd1,
      wb_req_dmem   = 2'd2,
      wb_req_copro  = 2'd3
   } wb_req_e;

   // Next long-latency requester in rotation order 1 -> 2 -> 3 -> 1.
   function automatic wb_req_e wb_rr_next(input wb_req_e idx);
      wb_req_e nxt;
      if (idx == wb_req_copro) begin
         nxt = wb_req_muldiv;
      end else begin
         nxt = wb_req_e'(idx + 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/cpu_rr_arbiter.sv
// Rotating-priority picker for the three long-latency write-back requesters.
// Purely combinational: the caller owns the last-grant pointer.
module cpu_rr_arbiter
   import pck_control::*;
(
   input  logic [2:0] req,    // bit 0 = muldiv, bit 1 = dmem, bit 2 = copro
   input  wb_req_e    last,   // most recently granted long-latency requester
   output logic [2:0] grant   // one-hot, zero when no request
);

   wb_req_e cand;
   logic    found;

   // Scan the three slots starting just after the last winner.
   always_comb begin
      grant = '0;
      found = 1'b0;
      cand  = wb_rr_next(last);
      for (int i = 0; i < 3; i++) begin
         if (!found && cand != wb_req_pipe && req[int'(cand) - 1]) begin
            grant[int'(cand) - 1] = 1'b1;
            found                 = 1'b1;
         end
         cand = wb_rr_next(cand);
      end
   end

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Register-file write-port arbiter. The pipeline (slot 0) wins by default;
// long-latency units share the leftovers round-robin, and a starvation
// counter stalls the pipeline once a pending unit has lost too often.
module cpu_wb_arbiter
   import pck_control::*;
#(
   parameter int p_starve_max = 4,   // 1..15
   parameter int p_out_buf    = 1    // 1 = registered write port
)(
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic [WB_NB_REQ-1:0]                  i_req_valid,
   input  logic [WB_NB_REQ-1:0][WB_ADDR_W-1:0]   i_req_addr,
   input  logic [WB_NB_REQ-1:0][WB_DATA_W-1:0]   i_req_data,
   output logic [WB_NB_REQ-1:0]                  o_req_ready,
   output logic                                  o_stall_pipe,
   output logic                                  o_rf_wr_en,
   output logic [WB_ADDR_W-1:0]                  o_rf_wr_addr,
   output logic [WB_DATA_W-1:0]                  o_rf_wr_data
);

   localparam logic [3:0] STARVE_MAX = 4'(p_starve_max);

   logic [3:0]           starve_cnt;
   logic [3:0]           starve_cnt_nxt;
   wb_req_e              last_grant;
   wb_req_e              last_grant_nxt;
   logic                 any_late;
   logic                 starved;
   logic [2:0]           rr_grant;
   logic [WB_NB_REQ-1:0] grant;
   logic                 late_granted;
   logic                 transfer;
   wb_req_e              grant_idx;
   logic [WB_ADDR_W-1:0] sel_addr;
   logic [WB_DATA_W-1:0] sel_data;
   logic                 wr_now;

   assign any_late = |i_req_valid[WB_NB_REQ-1:1];
   assign starved  = any_late && (starve_cnt == STARVE_MAX);

   cpu_rr_arbiter u_rr (
      .req   (i_req_valid[WB_NB_REQ-1:1]),
      .last  (last_grant),
      .grant (rr_grant)
   );

   // Grant selection; ready is forced low while reset is asserted.
   always_comb begin
      grant = '0;
      if (i_rst_n) begin
         if (i_req_valid[wb_req_pipe] && !starved) begin
            grant[wb_req_pipe] = 1'b1;
         end else begin
            grant[WB_NB_REQ-1:1] = rr_grant;
         end
      end
   end

   assign o_req_ready  = grant;
   assign o_stall_pipe = starved;
   assign late_granted = |grant[WB_NB_REQ-1:1];
   assign transfer     = |grant;

   // Mux the winning requester onto the write path.
   always_comb begin
      grant_idx = wb_req_pipe;
      for (int k = 0; k < WB_NB_REQ; k++) begin
         if (grant[k]) begin
            grant_idx = wb_req_e'(2'(k));
         end
      end
   end

   assign sel_addr = i_req_addr[grant_idx];
   assign sel_data = i_req_data[grant_idx];
   // Writes to x0 are accepted from the requester but never reach the regfile.
   assign wr_now   = transfer && (sel_addr != '0);

   // Starvation counter and round-robin pointer next-state.
   always_comb begin
      starve_cnt_nxt = starve_cnt;
      last_grant_nxt = last_grant;
      if (late_granted || !any_late) begin
         starve_cnt_nxt = '0;
      end else if (starve_cnt < STARVE_MAX) begin
         starve_cnt_nxt = starve_cnt + 4'd1;
      end
      if (late_granted) begin
         last_grant_nxt = grant_idx;
      end
   end

   // Arbitration state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= '0;
         last_grant <= wb_req_copro;
      end else begin
         starve_cnt <= starve_cnt_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   generate
      if (p_out_buf != 0) begin : g_out_reg
         logic                 wr_en_q;
         logic [WB_ADDR_W-1:0] wr_addr_q;
         logic [WB_DATA_W-1:0] wr_data_q;

         // Registered write port; addr/data keep the last real write.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               wr_en_q   <= 1'b0;
               wr_addr_q <= '0;
               wr_data_q <= '0;
            end else begin
               wr_en_q <= wr_now;
               if (wr_now) begin
                  wr_addr_q <= sel_addr;
                  wr_data_q <= sel_data;
               end
            end
         end

         assign o_rf_wr_en   = wr_en_q;
         assign o_rf_wr_addr = wr_addr_q;
         assign o_rf_wr_data = wr_data_q;
      end else begin : g_out_comb
         logic [WB_ADDR_W-1:0] hold_addr;
         logic [WB_DATA_W-1:0] hold_data;

         // Remember the last real write so idle cycles show stable values.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               hold_addr <= '0;
               hold_data <= '0;
            end else if (wr_now) begin
               hold_addr <= sel_addr;
               hold_data <= sel_data;
            end
         end

         assign o_rf_wr_en   = wr_now;
         assign o_rf_wr_addr = wr_now ? sel_addr : hold_addr;
         assign o_rf_wr_data = wr_now ? sel_data : hold_data;
      end
   endgenerate

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Bench for cpu_wb_arbiter: a registered and a combinational instance share
// stimulus; arbitration is table driven, regfile writes go via a scoreboard.
module tb_cpu_wb_arbiter;
   import pck_control::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]        req_valid;
   logic [3:0][4:0]   req_addr;
   logic [3:0][31:0]  req_data;

   logic [3:0]  b_ready, c_ready;
   logic        b_stall, c_stall;
   logic        b_en, c_en;
   logic [4:0]  b_addr, c_addr;
   logic [31:0] b_data, c_data;

   cpu_wb_arbiter #(.p_starve_max(4), .p_out_buf(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
      .i_req_addr(req_addr), .i_req_data(req_data), .o_req_ready(b_ready),
      .o_stall_pipe(b_stall), .o_rf_wr_en(b_en), .o_rf_wr_addr(b_addr),
      .o_rf_wr_data(b_data));

   cpu_wb_arbiter #(.p_starve_max(4), .p_out_buf(0)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
      .i_req_addr(req_addr), .i_req_data(req_data), .o_req_ready(c_ready),
      .o_stall_pipe(c_stall), .o_rf_wr_en(c_en), .o_rf_wr_addr(c_addr),
      .o_rf_wr_data(c_data));

   typedef struct {
      logic [3:0]       valid;
      logic [3:0][4:0]  addr;
      logic [3:0][31:0] data;
      logic [3:0]       exp_ready;
      logic             exp_stall;
      string            name;
   } vec_t;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   vec_t        vecs[$];
   wr_t         sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] v,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] a3,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3,
                      input logic [3:0] er, input logic es, input string nm);
      vec_t x;
      x.valid = v;
      x.addr[0] = a0; x.addr[1] = a1; x.addr[2] = a2; x.addr[3] = a3;
      x.data[0] = d0; x.data[1] = d1; x.data[2] = d2; x.data[3] = d3;
      x.exp_ready = er;
      x.exp_stall = es;
      x.name = nm;
      vecs.push_back(x);
   endtask

   // One arbitration cycle: drive, check grant and same-cycle write, then
   // check the registered write one edge later through the scoreboard.
   task automatic step(input vec_t v);
      wr_t e;
      wr_t got;
      @(negedge clk);
      req_valid = v.valid;
      req_addr  = v.addr;
      req_data  = v.data;
      #1;
      chk({v.name, " ready_b"}, 32'(b_ready), 32'(v.exp_ready));
      chk({v.name, " ready_c"}, 32'(c_ready), 32'(v.exp_ready));
      chk({v.name, " stall"},   32'(b_stall), 32'(v.exp_stall));
      e.en = 1'b0;
      e.addr = m_addr;
      e.data = m_data;
      for (int i = 0; i < 4; i++) begin
         if (v.exp_ready[i] && v.addr[i] != 5'd0) begin
            e.en = 1'b1;
            e.addr = v.addr[i];
            e.data = v.data[i];
         end
      end
      chk({v.name, " comb_en"},   32'(c_en),   32'(e.en));
      chk({v.name, " comb_addr"}, 32'(c_addr), 32'(e.addr));
      chk({v.name, " comb_data"}, c_data,      e.data);
      m_addr = e.addr;
      m_data = e.data;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard: got empty queue expected entry", v.name);
      end else begin
         got = sb.pop_front();
         chk({v.name, " reg_en"},   32'(b_en),   32'(got.en));
         chk({v.name, " reg_addr"}, 32'(b_addr), 32'(got.addr));
         chk({v.name, " reg_data"}, b_data,      got.data);
      end
   endtask

   initial begin
      vec_t v;

      // Single pipeline write.
      add(4'b0001, 5'd5, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 0, 0, 0, 4'b0001, 1'b0, "pipe_only");
      add(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 4'b0000, 1'b0, "idle_hold");
      // x0 write from copro: accepted, never written.
      add(4'b1000, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h1234, 4'b1000, 1'b0, "x0_copro");
      // Round robin with all three late requesters pending (last = 3).
      for (int r = 0; r < 2; r++) begin
         add(4'b1110, 5'd0, 5'd1, 5'd2, 5'd3, 0, 32'h11111111, 32'h22222222, 32'h33333333, 4'b0010, 1'b0, "rr_1");
         add(4'b1110, 5'd0, 5'd1, 5'd2, 5'd3, 0, 32'h11111111, 32'h22222222, 32'h33333333, 4'b0100, 1'b0, "rr_2");
         add(4'b1110, 5'd0, 5'd1, 5'd2, 5'd3, 0, 32'h11111111, 32'h22222222, 32'h33333333, 4'b1000, 1'b0, "rr_3");
      end
      // Starvation: pipe wins 4 times, then dmem is forced through.
      for (int r = 0; r < 4; r++)
         add(4'b0101, 5'd7, 5'd0, 5'd9, 5'd0, 32'h70, 0, 32'h90, 0, 4'b0001, 1'b0, "starve_pipe");
      add(4'b0101, 5'd7, 5'd0, 5'd9, 5'd0, 32'h70, 0, 32'h90, 0, 4'b0100, 1'b1, "starve_hit");
      add(4'b0101, 5'd7, 5'd0, 5'd9, 5'd0, 32'h70, 0, 32'h90, 0, 4'b0001, 1'b0, "starve_cleared");
      // Rotation wraps past slot 2 to 3 then to 1 (last = 2).
      add(4'b1010, 5'd0, 5'd4, 5'd0, 5'd6, 0, 32'h44, 0, 32'h66, 4'b1000, 1'b0, "rr_wrap_3");
      add(4'b1010, 5'd0, 5'd4, 5'd0, 5'd6, 0, 32'h44, 0, 32'h66, 4'b0010, 1'b0, "rr_wrap_1");
      // Counter reset when no late requester is valid.
      for (int r = 0; r < 2; r++)
         add(4'b0101, 5'd8, 5'd0, 5'd10, 5'd0, 32'h80, 0, 32'hA0, 0, 4'b0001, 1'b0, "cnt_pre");
      add(4'b0001, 5'd8, 5'd0, 5'd0, 5'd0, 32'h81, 0, 0, 0, 4'b0001, 1'b0, "cnt_clear");
      for (int r = 0; r < 4; r++)
         add(4'b0101, 5'd8, 5'd0, 5'd10, 5'd0, 32'h82, 0, 32'hA0, 0, 4'b0001, 1'b0, "cnt_post");
      add(4'b0101, 5'd8, 5'd0, 5'd10, 5'd0, 32'h82, 0, 32'hA0, 0, 4'b0100, 1'b1, "cnt_post_hit");
      // All-ones write from dmem.
      add(4'b0100, 5'd0, 5'd0, 5'd31, 5'd0, 0, 0, 32'hFFFFFFFF, 0, 4'b0100, 1'b0, "dmem_max");

      // Reset: ready must stay low even with every requester valid.
      req_valid = 4'hF;
      req_addr  = '0;
      req_data  = '0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready_b", 32'(b_ready), 32'h0);
      chk("rst ready_c", 32'(c_ready), 32'h0);
      chk("rst wr_en",   32'(b_en),    32'h0);
      chk("rst wr_addr", 32'(b_addr),  32'h0);
      chk("rst wr_data", b_data,       32'h0);
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b1;

      foreach (vecs[i]) step(vecs[i]);

      // Reset right after a muldiv transfer drops the pending write.
      @(negedge clk);
      req_valid = 4'b0010;
      req_addr  = '0;
      req_data  = '0;
      req_addr[1] = 5'd4;
      req_data[1] = 32'hABCD;
      #1;
      chk("prerst ready", 32'(b_ready), 32'b0010);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst wr_en",   32'(b_en),    32'h0);
      chk("midrst wr_addr", 32'(b_addr),  32'h0);
      chk("midrst ready",   32'(b_ready), 32'h0);
      @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_addr = '0;
      m_data = '0;
      sb.delete();
      @(posedge clk);
      #1;
      chk("postrst wr_en", 32'(b_en), 32'h0);
      v.valid = 4'b1110;
      v.addr = '0;
      v.data = '0;
      v.addr[1] = 5'd1; v.addr[2] = 5'd2; v.addr[3] = 5'd3;
      v.data[1] = 32'h1; v.data[2] = 32'h2; v.data[3] = 32'h3;
      v.exp_ready = 4'b0010;
      v.exp_stall = 1'b0;
      v.name = "postrst_rr";
      step(v);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_wb_arbiter.md
CPU_WB_ARBITER -- requirements
Module: cpu_wb_arbiter

Interface
REQ-001 SHALL have parameter p_starve_max, default 4, meaning cycles a pending long-latency requester may lose to the pipeline before the pipeline is stalled (legal 1..15).
REQ-002 SHALL have parameter p_out_buf, default 1, meaning 1 = registered regfile write outputs, 0 = combinational.
REQ-003 SHALL have port i_clk, input, 1, the single global clock.
REQ-004 SHALL have port i_rst_n, input, 1: the reset is asynchronous and active-low.
REQ-005 SHALL have port i_req_valid, input, 4, per-requester write request (0 = pipeline, 1 = muldiv, 2 = dmem load, 3 = coprocessor).
REQ-006 SHALL have port i_req_addr, input, 4x5, per-requester destination register.
REQ-007 SHALL have port i_req_data, input, 4x32, per-requester write data.
REQ-008 SHALL have port o_req_ready, output, 4, per-requester accept (one-hot or zero).
REQ-009 SHALL have port o_stall_pipe, output, 1, stall request to the pipeline while starvation is resolved.
REQ-010 SHALL have ports o_rf_wr_en, o_rf_wr_addr and o_rf_wr_data: outputs of width 1, 5 and 32, forming the regfile write port.

Function
REQ-011 SHALL transfer a request when i_req_valid[k] and o_req_ready[k] are both 1; requesters hold valid, addr and data stable until accepted.
REQ-012 SHALL assert at most one o_req_ready bit per cycle, and only for a valid requester.
REQ-013 SHALL grant requester 0 whenever it is valid and the starvation counter is below p_starve_max.
REQ-014 SHALL otherwise grant among requesters 1..3 round-robin, starting at the index after the last granted one (order 1->2->3->1).
REQ-015 SHALL keep a starvation counter that increments, saturating at p_starve_max, in each cycle where any of 1..3 is valid and none of them is granted.
REQ-016 SHALL clear the starvation counter in any cycle where one of 1..3 is granted, or where none of 1..3 is valid.
REQ-017 SHALL drive o_stall_pipe=1 and o_req_ready[0]=0 combinationally when the counter equals p_starve_max and any of 1..3 is valid.
REQ-018 SHALL update the round-robin pointer only on a grant to 1..3.
REQ-019 SHALL, with p_out_buf=1, present the accepted addr and data with o_rf_wr_en=1 exactly one cycle after the transfer, and drive o_rf_wr_en=0 in cycles following no transfer.
REQ-020 SHALL, with p_out_buf=0, present the write in the same cycle as the transfer.
REQ-021 SHALL accept requests to register x0 normally but drive o_rf_wr_en=0 for them.
REQ-022 SHALL hold o_rf_wr_addr and o_rf_wr_data at their last written values when o_rf_wr_en=0.
REQ-023 SHALL hold all ready outputs at 0 during reset.

Reset
REQ-024 SHALL asynchronously set o_rf_wr_en=0, o_rf_wr_addr=0, o_rf_wr_data=0, the starvation counter to 0 and the round-robin last-grant to 3 when i_rst_n=0.
REQ-025 SHALL discard any accepted but not yet written request on reset; no write occurs after release.
REQ-026 SHALL resume arbitration on the first rising edge after i_rst_n deasserts.

Structure
REQ-027 SHALL take requester indices from enum wb_req_e in package pck_control (wb_req_pipe, wb_req_muldiv, wb_req_dmem, wb_req_copro), together with constant WB_NB_REQ=4.
REQ-028 SHALL place the 3-way rotating-priority picker in sub-module cpu_rr_arbiter (combinational: request vector and last grant in, one-hot grant out).
REQ-029 SHALL keep all state (counter, pointer, output registers) in cpu_wb_arbiter.

Verification
REQ-030 SHALL test: req0 only, addr=5, data=0xDEADBEEF -> ready[0]=1, and one cycle later o_rf_wr_en=1, addr=5, data=0xDEADBEEF.
REQ-031 SHALL test: req0 held valid plus req2 valid with p_starve_max=4 -> req0 granted 4 cycles, then in cycle 5 o_stall_pipe=1 and ready[2]=1, and the counter returns to 0.
REQ-032 SHALL test: req1, req2 and req3 all valid continuously, req0 idle -> grants in order 1,2,3,1,2,3.
REQ-033 SHALL test: req3 valid, addr=0, data=0x1234 -> ready[3]=1, and o_rf_wr_en stays 0.
REQ-034 SHALL test: i_rst_n pulled low the cycle after a req1 transfer -> o_rf_wr_en=0 immediately, with no write after release and the first round-robin grant going to 1.
REQ-035 SHALL test: p_out_buf=0, req2 valid, addr=31, data=0xFFFFFFFF -> o_rf_wr_en=1 with addr=31 and data=0xFFFFFFFF in the same cycle.
